// File: rtl/riego_pkg.sv
// ============================================================================
// Module : riego_pkg
// Brief  : Shared types, threshold table and quiet-hour constants for riego_ctrl
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riego_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RIEGO = 2'd1,
        ST_PAUSA = 2'd2,
        ST_FALLA = 2'd3
    } estado_t;

    typedef struct packed {
        logic [11:0] bajo;
        logic [11:0] alto;
    } umbral_t;

    localparam logic [7:0] C_HORA_SILENCIO_INI = 8'h22;
    localparam logic [7:0] C_HORA_SILENCIO_FIN = 8'h06;
    localparam logic [7:0] C_HORA_MAX          = 8'h23;
    localparam logic [7:0] C_MINUTO_MAX        = 8'h59;

    // Unknown plant types fall back to the generic (type 1) thresholds.
    function automatic umbral_t umbral(input logic [3:0] tipo);
        umbral_t u;
        case (tipo)
            4'd0:    u = '{bajo: 12'h200, alto: 12'h400};
            4'd2:    u = '{bajo: 12'h800, alto: 12'hB00};
            4'd3:    u = '{bajo: 12'hA00, alto: 12'hD00};
            default: u = '{bajo: 12'h500, alto: 12'h800};
        endcase
        return u;
    endfunction

endpackage

`default_nettype wire

// File: rtl/riego_ctrl_if.sv
// ============================================================================
// Module : riego_ctrl_if
// Brief  : Sample-in / pump-control-out bundle between decoder side and riego_ctrl
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface riego_ctrl_if;
    logic        listo;
    logic [11:0] humedad;
    logic [15:0] hora;
    logic [3:0]  tipoPlanta;
    logic        MODbomba;
    logic        activarB;
    logic        alarma_req;
    logic [1:0]  estado;
    logic [2:0]  intentos;

    modport master (
        output listo, humedad, hora, tipoPlanta, MODbomba,
        input  activarB, alarma_req, estado, intentos
    );

    modport slave (
        input  listo, humedad, hora, tipoPlanta, MODbomba,
        output activarB, alarma_req, estado, intentos
    );
endinterface

`default_nettype wire

// File: rtl/riego_ctrl_franja_silencio.sv
// ============================================================================
// Module : franja_silencio
// Brief  : Flags BCD HH:MM times that are malformed or inside the night window
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module franja_silencio
    import riego_pkg::*;
(
    input  wire logic [15:0] hora_i,
    output logic             silencio_o
);

    logic [7:0] w_hh;
    logic [7:0] w_mm;
    logic       w_bcd_ok;
    logic       w_valida;

    assign w_hh = hora_i[15:8];
    assign w_mm = hora_i[7:0];

    assign w_bcd_ok = (hora_i[15:12] <= 4'd9) && (hora_i[11:8] <= 4'd9) &&
                      (hora_i[7:4]   <= 4'd9) && (hora_i[3:0]  <= 4'd9);

    assign w_valida = w_bcd_ok && (w_hh <= C_HORA_MAX) && (w_mm <= C_MINUTO_MAX);

    // Once the digits are valid BCD, raw unsigned compares order hours correctly.
    assign silencio_o = !w_valida ||
                        (w_hh >= C_HORA_SILENCIO_INI) ||
                        (w_hh <  C_HORA_SILENCIO_FIN);

endmodule

`default_nettype wire

// File: rtl/riego_ctrl.sv
// ============================================================================
// Module : riego_ctrl
// Brief  : Hysteresis watering controller with timed water/soak FSM and fault latch
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module riego_ctrl
    import riego_pkg::*;
#(
    parameter logic [31:0] T_RIEGO      = 32'd250_000_000,
    parameter logic [31:0] T_PAUSA      = 32'd500_000_000,
    parameter int unsigned MAX_INTENTOS = 3
) (
    input  wire logic   clk,
    input  wire logic   rst,
    riego_ctrl_if.slave bus
);

    logic        listo_q;
    logic        flanco_q;
    logic        nuevo_q;
    logic [11:0] humedad_q;
    logic [15:0] hora_q;
    logic [3:0]  tipo_q;

    estado_t     estado_q, estado_d;
    logic [31:0] timer_q, timer_d;
    logic [2:0]  intentos_q, intentos_d;
    logic        activarB_q;
    logic        alarma_q;

    logic        w_flanco;
    logic        w_silencio;
    logic        w_seco;
    logic        w_mojado;
    logic [2:0]  w_intentos_inc;
    logic [31:0] w_timer_inc;
    umbral_t     w_umbral;

    assign w_flanco = bus.listo && !listo_q;

    franja_silencio u_franja_silencio (
        .hora_i     (hora_q),
        .silencio_o (w_silencio)
    );

    assign w_umbral       = umbral(tipo_q);
    assign w_seco         = humedad_q <  w_umbral.bajo;
    assign w_mojado       = humedad_q >= w_umbral.alto;
    assign w_intentos_inc = intentos_q + 3'd1;
    assign w_timer_inc    = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;

    always_comb begin
        estado_d   = estado_q;
        timer_d    = w_timer_inc;
        intentos_d = intentos_q;
        case (estado_q)
            ST_IDLE: begin
                timer_d = 32'd0;
                if (nuevo_q && w_mojado) begin
                    intentos_d = 3'd0;
                end
                if (bus.MODbomba && nuevo_q && w_seco && !w_silencio) begin
                    estado_d = ST_RIEGO;
                end
            end
            ST_RIEGO: begin
                if (!bus.MODbomba) begin
                    estado_d = ST_IDLE;
                    timer_d  = 32'd0;
                end else if (timer_q >= T_RIEGO - 32'd1) begin
                    // Timeout wins over a sample arriving in the same cycle.
                    intentos_d = w_intentos_inc;
                    timer_d    = 32'd0;
                    estado_d   = (32'(w_intentos_inc) >= MAX_INTENTOS) ? ST_FALLA : ST_PAUSA;
                end else if (nuevo_q && w_mojado) begin
                    estado_d   = ST_IDLE;
                    intentos_d = 3'd0;
                    timer_d    = 32'd0;
                end else if (nuevo_q && w_silencio) begin
                    estado_d = ST_IDLE;
                    timer_d  = 32'd0;
                end
            end
            ST_PAUSA: begin
                if (!bus.MODbomba || (timer_q >= T_PAUSA - 32'd1)) begin
                    estado_d = ST_IDLE;
                    timer_d  = 32'd0;
                end
            end
            default: begin
                timer_d = timer_q;
            end
        endcase
    end

    // nuevo trails the captured sample by one cycle so the FSM always sees
    // settled thresholds and quiet-window decode for that sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            listo_q    <= 1'b0;
            flanco_q   <= 1'b0;
            nuevo_q    <= 1'b0;
            humedad_q  <= 12'd0;
            hora_q     <= 16'd0;
            tipo_q     <= 4'd0;
            estado_q   <= ST_IDLE;
            timer_q    <= 32'd0;
            intentos_q <= 3'd0;
            activarB_q <= 1'b0;
            alarma_q   <= 1'b0;
        end else begin
            listo_q  <= bus.listo;
            flanco_q <= w_flanco;
            nuevo_q  <= flanco_q;
            if (w_flanco) begin
                humedad_q <= bus.humedad;
                hora_q    <= bus.hora;
                tipo_q    <= bus.tipoPlanta;
            end
            estado_q   <= estado_d;
            timer_q    <= timer_d;
            intentos_q <= intentos_d;
            activarB_q <= (estado_d == ST_RIEGO) && bus.MODbomba;
            alarma_q   <= (estado_d == ST_FALLA);
        end
    end

    assign bus.activarB   = activarB_q;
    assign bus.alarma_req = alarma_q;
    assign bus.estado     = estado_q;
    assign bus.intentos   = intentos_q;

endmodule

`default_nettype wire

// File: tb/tb_riego_ctrl.sv
// ============================================================================
// Module : tb_riego_ctrl
// Brief  : Directed self-checking bench for riego_ctrl (T_RIEGO=8, T_PAUSA=4, MAX=3)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_riego_ctrl;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    riego_ctrl_if bus();

    riego_ctrl #(
        .T_RIEGO      (32'd8),
        .T_PAUSA      (32'd4),
        .MAX_INTENTOS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a sample with a one-cycle listo pulse; returns on the negedge after
    // the detecting posedge. The FSM reacts two negedges later.
    task automatic send_sample(input logic [11:0] hum, input logic [15:0] hh, input logic [3:0] tipo);
        bus.humedad    = hum;
        bus.hora       = hh;
        bus.tipoPlanta = tipo;
        bus.listo      = 1'b1;
        @(negedge clk);
        bus.listo      = 1'b0;
    endtask

    task automatic stop_wet();
        send_sample(12'h900, 16'h1030, 4'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.estado !== 2'd0 || bus.activarB !== 1'b0 || bus.alarma_req !== 1'b0 || bus.intentos !== 3'd0) begin
            n_fail++;
            $display("FAIL reset: estado=%0d activarB=%0b alarma=%0b intentos=%0d, expected 0/0/0/0",
                     bus.estado, bus.activarB, bus.alarma_req, bus.intentos);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start();
        send_sample(12'h300, 16'h1030, 4'd1);
        @(negedge clk);
        n_tests++;
        if (bus.estado !== 2'd0 || bus.activarB !== 1'b0) begin
            n_fail++;
            $display("FAIL start_latency: estado=%0d activarB=%0b one cycle early, expected 0/0", bus.estado, bus.activarB);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.estado !== 2'd1 || bus.activarB !== 1'b1) begin
                n_fail++;
                $display("FAIL start_riego[%0d]: estado=%0d activarB=%0b, expected 1/1", i, bus.estado, bus.activarB);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.estado !== 2'd2 || bus.activarB !== 1'b0) begin
                n_fail++;
                $display("FAIL start_pausa[%0d]: estado=%0d activarB=%0b, expected 2/0", i, bus.estado, bus.activarB);
            end
        end
        @(negedge clk);
        n_tests++;
        if (bus.estado !== 2'd0 || bus.intentos !== 3'd1) begin
            n_fail++;
            $display("FAIL start_end: estado=%0d intentos=%0d, expected 0/1", bus.estado, bus.intentos);
        end
    endtask

    task automatic test_wet_stop();
        send_sample(12'h300, 16'h1030, 4'd1);
        repeat (2) @(negedge clk);
        send_sample(12'h900, 16'h1030, 4'd1);
        @(negedge clk);
        n_tests++;
        if (bus.estado !== 2'd1) begin
            n_fail++;
            $display("FAIL wet_before: estado=%0d, expected 1", bus.estado);
        end
        @(negedge clk);
        n_tests++;
        if (bus.estado !== 2'd0 || bus.activarB !== 1'b0 || bus.intentos !== 3'd0) begin
            n_fail++;
            $display("FAIL wet_stop: estado=%0d activarB=%0b intentos=%0d, expected 0/0/0",
                     bus.estado, bus.activarB, bus.intentos);
        end
    endtask

    task automatic test_quiet();
        logic [15:0] horas [3];
        logic [1:0]  esperado [3];
        horas    = '{16'h2300, 16'h0575, 16'h0600};
        esperado = '{2'd0, 2'd0, 2'd1};
        for (int i = 0; i < 3; i++) begin
            send_sample(12'h100, horas[i], 4'd1);
            repeat (2) @(negedge clk);
            n_tests++;
            if (bus.estado !== esperado[i]) begin
                n_fail++;
                $display("FAIL quiet hora=%h: estado=%0d, expected %0d", horas[i], bus.estado, esperado[i]);
            end
        end
        stop_wet();
    endtask

    task automatic test_thresholds();
        logic [11:0] hums  [3];
        logic [3:0]  tipos [3];
        logic [1:0]  esperado [3];
        hums     = '{12'h200, 12'h9FF, 12'h4FF};
        tipos    = '{4'd0, 4'd3, 4'd9};
        esperado = '{2'd0, 2'd1, 2'd1};
        for (int i = 0; i < 3; i++) begin
            send_sample(hums[i], 16'h1200, tipos[i]);
            repeat (2) @(negedge clk);
            n_tests++;
            if (bus.estado !== esperado[i]) begin
                n_fail++;
                $display("FAIL umbral tipo=%0d hum=%h: estado=%0d, expected %0d", tipos[i], hums[i], bus.estado, esperado[i]);
            end
            if (esperado[i] == 2'd1) stop_wet();
        end
    endtask

    task automatic test_mod_removed();
        send_sample(12'h300, 16'h1030, 4'd1);
        repeat (14) @(negedge clk);
        send_sample(12'h300, 16'h1030, 4'd1);
        repeat (2) @(negedge clk);
        bus.MODbomba = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.estado !== 2'd0 || bus.activarB !== 1'b0 || bus.intentos !== 3'd1) begin
            n_fail++;
            $display("FAIL mod_drop: estado=%0d activarB=%0b intentos=%0d, expected 0/0/1",
                     bus.estado, bus.activarB, bus.intentos);
        end
        send_sample(12'h300, 16'h1030, 4'd1);
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.estado !== 2'd0 || bus.activarB !== 1'b0) begin
            n_fail++;
            $display("FAIL mod_blocked: estado=%0d activarB=%0b, expected 0/0", bus.estado, bus.activarB);
        end
        bus.MODbomba = 1'b1;
        stop_wet();
        n_tests++;
        if (bus.intentos !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_wet_clear: intentos=%0d, expected 0", bus.intentos);
        end
    endtask

    task automatic test_fault();
        for (int k = 1; k <= 3; k++) begin
            send_sample(12'h300, 16'h1030, 4'd1);
            repeat (10) @(negedge clk);
            if (k < 3) begin
                n_tests++;
                if (bus.estado !== 2'd2) begin
                    n_fail++;
                    $display("FAIL fault_pausa%0d: estado=%0d, expected 2", k, bus.estado);
                end
                repeat (4) @(negedge clk);
                n_tests++;
                if (bus.estado !== 2'd0 || bus.intentos !== 3'(k)) begin
                    n_fail++;
                    $display("FAIL fault_idle%0d: estado=%0d intentos=%0d, expected 0/%0d", k, bus.estado, bus.intentos, k);
                end
            end
        end
        n_tests++;
        if (bus.estado !== 2'd3 || bus.alarma_req !== 1'b1 || bus.intentos !== 3'd3 || bus.activarB !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_latch: estado=%0d alarma=%0b intentos=%0d activarB=%0b, expected 3/1/3/0",
                     bus.estado, bus.alarma_req, bus.intentos, bus.activarB);
        end
        stop_wet();
        send_sample(12'h300, 16'h1030, 4'd1);
        bus.MODbomba = 1'b0;
        repeat (3) @(negedge clk);
        bus.MODbomba = 1'b1;
        repeat (12) @(negedge clk);
        n_tests++;
        if (bus.estado !== 2'd3 || bus.alarma_req !== 1'b1 || bus.intentos !== 3'd3) begin
            n_fail++;
            $display("FAIL fault_absorb: estado=%0d alarma=%0b intentos=%0d, expected 3/1/3",
                     bus.estado, bus.alarma_req, bus.intentos);
        end
    endtask

    task automatic test_level_hold_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (bus.estado !== 2'd0 || bus.alarma_req !== 1'b0 || bus.intentos !== 3'd0) begin
            n_fail++;
            $display("FAIL fault_clear: estado=%0d alarma=%0b intentos=%0d, expected 0/0/0",
                     bus.estado, bus.alarma_req, bus.intentos);
        end
        bus.humedad    = 12'h300;
        bus.hora       = 16'h1030;
        bus.tipoPlanta = 4'd1;
        bus.listo      = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.estado !== 2'd1) begin
            n_fail++;
            $display("FAIL hold_start: estado=%0d, expected 1", bus.estado);
        end
        repeat (17) @(negedge clk);
        bus.listo = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (bus.estado !== 2'd0 || bus.intentos !== 3'd1) begin
            n_fail++;
            $display("FAIL hold_single: estado=%0d intentos=%0d, expected 0/1", bus.estado, bus.intentos);
        end
        send_sample(12'h300, 16'h1030, 4'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.estado !== 2'd0 || bus.activarB !== 1'b0 || bus.alarma_req !== 1'b0 || bus.intentos !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_riego: estado=%0d activarB=%0b alarma=%0b intentos=%0d, expected 0/0/0/0",
                     bus.estado, bus.activarB, bus.alarma_req, bus.intentos);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.listo      = 1'b0;
        bus.humedad    = 12'd0;
        bus.hora       = 16'h1200;
        bus.tipoPlanta = 4'd0;
        bus.MODbomba   = 1'b1;
        test_reset();
        test_start();
        test_wet_stop();
        test_quiet();
        test_thresholds();
        test_mod_removed();
        test_fault();
        test_level_hold_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riego_ctrl.md
# riego_ctrl

Watering controller downstream of the serial decoder. Consumes each decoded sample (humidity, time, plant type, valid level), compares humidity against per-plant hysteresis thresholds, and drives the water-pump enable through a timed water/soak state machine. Repeated watering that fails to raise humidity latches a fault and drives the alarm melody request.

## Interface
- `T_RIEGO`, 32'd250_000_000: max pump-on time per attempt, clk cycles
- `T_PAUSA`, 32'd500_000_000: soak time after a timed-out attempt, clk cycles
- `MAX_INTENTOS`, 3: consecutive timed-out attempts before fault, 1..7
- `clk` in 1: system clock; one clock domain
- `rst` in 1: reset, synchronous, active-high
- `listo` in 1: decoder data-valid level; a rising edge marks a new sample
- `humedad` in 12: raw moisture, larger = wetter
- `hora` in 16: BCD HH:MM, [15:8] hours, [7:0] minutes
- `tipoPlanta` in 4: plant type index
- `MODbomba` in 1: pump module connected
- `activarB` out 1: pump enable
- `alarma_req` out 1: fault flag, feeds the alarm melody `regar` input
- `estado` out 2: current state code
- `intentos` out 3: consecutive timed-out attempts

## Operation
- States: IDLE=0, RIEGO=1, PAUSA=2, FALLA=3. `activarB` = (estado==RIEGO) && MODbomba. `alarma_req` = (estado==FALLA).
- Sample capture: `listo` registered into `listo_q`. When `listo && !listo_q`, `humedad`, `hora`, and `tipoPlanta` are registered and a one-cycle `nuevo` pulse is raised on the next cycle. The FSM acts only on `nuevo`. Levels of `listo` held high never re-trigger.
- Thresholds (bajo/alto) by registered type: 0 → 0x200/0x400; 1 → 0x500/0x800; 2 → 0x800/0xB00; 3 → 0xA00/0xD00; 4..15 → same as type 1. Compares are unsigned 12-bit.
- Quiet window: hour ≥ 0x22 or hour < 0x06. Any non-BCD nibble, hour > 0x23, or minute > 0x59 is also treated as quiet.
- IDLE → RIEGO: on `nuevo` with humedad < bajo, not quiet, and MODbomba=1. Timer is cleared.
- RIEGO transitions:
  - `nuevo` with humedad ≥ alto → IDLE, intentos cleared.
  - `nuevo` in quiet window → IDLE, intentos unchanged.
  - Timer reaches T_RIEGO-1 → intentos+1. If the new value is ≥ MAX_INTENTOS → FALLA, else → PAUSA with timer cleared.
  - Timeout takes priority over a `nuevo` in the same cycle.
- PAUSA: ignores samples. Timer reaches T_PAUSA-1 → IDLE.
- FALLA: absorbing state; left only by `rst`. intentos frozen.
- MODbomba=0 in IDLE/RIEGO/PAUSA: next cycle → IDLE with timer cleared and intentos unchanged. IDLE start is blocked while MODbomba=0.
- Any `nuevo` with humedad ≥ alto seen in IDLE clears intentos.

## Timing
- Reset values: estado=IDLE, activarB=0, alarma_req=0, intentos=0, timer=0, listo_q=0, sample registers=0.
- Latency: `listo` rises at edge n → sample registered at edge n → `nuevo` high in cycle n+1 → estado=RIEGO and `activarB`=1 after edge n+2.
- RIEGO lasts exactly T_RIEGO cycles when it times out. PAUSA lasts exactly T_PAUSA cycles.
- Timer is 32 bits and saturates; it never wraps.
- `rst` mid-RIEGO: pump is off in the cycle after the reset edge.
- All outputs are decoded from registers only; there are no combinational paths from inputs to outputs.

## Structure
- Package `riego_pkg`: state enum and codes, threshold table function `umbral(tipo)` returning {bajo, alto}, quiet-hour BCD constants 8'h22 / 8'h06.
- One sub-module, `franja_silencio`: combinational BCD validity check plus quiet-window check on `hora`, output `silencio`.
- Top level of the block holds the edge detector, sample registers, timer, intentos counter, and FSM.

## Test plan
Parameters for all scenarios: T_RIEGO=8, T_PAUSA=4, MAX_INTENTOS=3.
- **Start watering:** type 1, humedad=0x300, hora=0x1030, MODbomba=1, `listo` rises → activarB=1 two cycles after the edge, held 8 cycles. Then estado=PAUSA for 4 cycles, then IDLE, intentos=1.
- **Wet stop:** during RIEGO, new sample humedad=0x900 (type 1) → IDLE the cycle after `nuevo`, activarB=0, intentos=0.
- **Fault:** three dry samples, each arriving in IDLE after a soak → after the third 8-cycle attempt estado=FALLA, alarma_req=1, intentos=3. Further samples are ignored until `rst`.
- **Quiet window:** hora=0x2300, humedad=0x100 → no start. hora=0x0575 (invalid minute) → no start. hora=0x0600 → start.
- **Pump module removed:** MODbomba dropped mid-RIEGO → IDLE next cycle, activarB=0, intentos unchanged. A dry sample while MODbomba=0 → stays IDLE.
- **Level hold and reset:** `listo` held high 20 cycles → exactly one `nuevo`. `rst` asserted in RIEGO → all outputs at reset values one cycle later.
